hamming_secded_decoder: RTL
===========================

HAMMING_SECDED_DECODER -- requirements
Module: hamming_secded_decoder

Interface
REQ-001 SHALL have parameter DATA_W, default 11, giving the data width (4..57).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of each error counter.
REQ-003 SHALL derive R as the smallest value with 2^R >= DATA_W+R+1, and CODE_W = DATA_W+R+1 (16 at default).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 parity_type  in  1  0 = even parity, 1 = odd parity; sampled with in_valid.
REQ-007 in_valid, in_ready  in/out  1  input handshake; transfer occurs when both are 1.
REQ-008 code_in  in  CODE_W  received codeword.
REQ-009 out_valid, out_ready  out/in  1  output handshake.
REQ-010 data_out  out  DATA_W  corrected data.
REQ-011 err_single / err_double  out  1/1  corrected single-bit error / detected uncorrectable error.
REQ-012 err_pos  out  R+1  flipped bit position; 0 when no single-bit error.

Function
REQ-013 Codeword layout SHALL be fixed as follows.
- Bit 0: overall parity.
- Positions 2^k (k=0..R-1): Hamming parity bits.
- Remaining positions 1..CODE_W-1, ascending: data[0..DATA_W-1].
REQ-014 Syndrome bit k SHALL be the XOR of all positions p>=1 with bit k of p set, XOR parity_type.
REQ-015 Overall check P SHALL be the XOR of all CODE_W bits, XOR parity_type.
REQ-016 Classification SHALL be:
- S=0, P=0: clean.
- P=1, S<CODE_W: single error at position S; S=0 means bit 0. Flip that bit.
- P=0, S!=0: double error.
- P=1, S>=CODE_W: double error; no flip.
REQ-017 On a double error, data_out SHALL carry the uncorrected data bits, with err_double=1 and err_pos=0.
REQ-018 The pipeline SHALL have two stages.
- Stage 1 registers the codeword, S and P.
- Stage 2 registers the corrected outputs.
- Latency is 2 cycles from input transfer to out_valid with out_ready held high.
REQ-019 Throughput SHALL be one word per cycle when out_ready=1.
REQ-020 A stage SHALL advance when it is empty or the stage after it is consumed.
- in_ready = !s1_valid || stage1 advances (combinational from out_ready).
REQ-021 Outputs SHALL remain stable while out_valid=1 and out_ready=0; no word may be lost or duplicated.
REQ-022 When both stages are full and out_ready=0, in_ready SHALL be 0.

Reset
REQ-023 While rst_n=0 at a clock edge, both stage valids SHALL clear, out_valid=0, data_out=0, err_single=0, err_double=0, err_pos=0.
REQ-024 A reset asserted mid-stream SHALL drop in-flight words.
- in_ready SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-025 When HAM_ERR_CNT_EN is defined, the block SHALL add the following.
- Input cnt_clr.
- Outputs cnt_single and cnt_double (CNT_W each), reset to 0.
- Counters increment on each output transfer flagged single/double and saturate at all-ones.
- cnt_clr has priority over increment.
REQ-026 When HAM_ERR_CNT_EN is undefined, these ports and counters SHALL be absent and the datapath SHALL be unchanged.

Structure
REQ-027 Package ham_pkg SHALL hold the R/CODE_W derivation function, the position-to-data-index mapping function and the err_class_t enum (CLEAN, SINGLE, DOUBLE).
REQ-028 Combinational sub-module ham_syndrome SHALL compute S and P; it is instantiated once in stage 1.

Verification (DATA_W=11, CODE_W=16)
REQ-029 Clean input: parity_type=0, code 16'h0000 -> 2 cycles later data 11'h000, no error flags, err_pos=0.
REQ-030 Single error: code 16'h0020 (position 5 flipped) -> data 11'h000, err_single=1, err_pos=5.
- Same test for code 16'h0001 -> err_pos=0.
REQ-031 Double error: code 16'h0028 (positions 3 and 5) -> err_double=1, err_single=0, err_pos=0.
REQ-032 Odd parity: parity_type=1, code 16'h0117 -> clean, data 11'h000.
- Same test for 16'h0116 -> err_single=1, err_pos=0.
REQ-033 Backpressure and reset:
- 4 back-to-back words with out_ready=0 for 5 cycles -> in_ready=0 after 2 accepted, all 4 delivered in order.
- rst_n low mid-stream -> out_valid=0 next cycle.
- With HAM_ERR_CNT_EN, 3 single-error words -> cnt_single=3; cnt_clr -> 0.

Source files
------------

// File: rtl/ham_pkg.sv
// ham_pkg -- shared definitions for the SECDED Hamming decoder.
//
// Contents:
//   err_class_t   : classification of a received word (CLEAN, SINGLE, DOUBLE)
//   calc_r        : number of Hamming parity bits R for a given data width
//   calc_code_w   : full codeword width (data + Hamming parity + overall parity)
//   is_pow2       : true for positions that hold Hamming parity bits
//   data_index    : maps a codeword position to its data bit index
//   syn_mask      : positions (>= 1) that feed syndrome bit k
//
// Codeword layout: bit 0 is the overall parity, positions 2^k hold Hamming
// parity, all other positions carry data bits in ascending order.
package ham_pkg;

    typedef enum logic [1:0] {
        CLEAN  = 2'd0,
        SINGLE = 2'd1,
        DOUBLE = 2'd2
    } err_class_t;

    // Smallest R with 2^R >= DATA_W + R + 1.
    function automatic int calc_r(input int data_w);
        int r;
        r = 1;
        while ((1 << r) < data_w + r + 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int calc_code_w(input int data_w);
        return data_w + calc_r(data_w) + 1;
    endfunction

    function automatic bit is_pow2(input int p);
        return (p > 0) && ((p & (p - 1)) == 0);
    endfunction

    // Data index of a non-power-of-two position: the number of data
    // positions that precede it.
    function automatic int data_index(input int pos);
        int idx;
        idx = 0;
        for (int q = 1; q < pos; q++) begin
            if (!is_pow2(q)) begin
                idx++;
            end
        end
        return idx;
    endfunction

    // 64 bits covers the widest codeword (DATA_W=57 -> 64 bits).
    function automatic logic [63:0] syn_mask(input int k);
        logic [63:0] m;
        m = '0;
        for (int p = 1; p < 64; p++) begin
            m[p] = (((p >> k) & 1) == 1);
        end
        return m;
    endfunction

endpackage

// File: rtl/ham_syndrome.sv
// ham_syndrome -- combinational syndrome and overall-parity check.
//
// Ports:
//   code        in  CODE_W  codeword to check
//   parity_type in  1       0 = even, 1 = odd parity
//   syn         out R       syndrome; nonzero points at a flipped position
//   chk         out 1       overall parity check (1 = odd number of flips)
module ham_syndrome
    import ham_pkg::*;
#(
    parameter int CODE_W = 16,
    parameter int R      = 4
) (
    input  logic [CODE_W-1:0] code,
    input  logic              parity_type,
    output logic [R-1:0]      syn,
    output logic              chk
);

    genvar gi;
    generate
        for (gi = 0; gi < R; gi++) begin : g_syn
            localparam logic [63:0] MASK64 = syn_mask(gi);
            assign syn[gi] = parity_type ^ (^(code & MASK64[CODE_W-1:0]));
        end
    endgenerate

    assign chk = parity_type ^ (^code);

endmodule

// File: rtl/hamming_secded_decoder.sv
// hamming_secded_decoder -- two-stage pipelined SECDED Hamming decoder.
//
// Stage 1 registers the codeword with its syndrome and overall parity;
// stage 2 registers the corrected data and error flags. Valid/ready
// handshakes on both sides; one word per cycle when out_ready is high.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   parity_type             0 = even, 1 = odd (sampled with in_valid)
//   in_valid/in_ready       input handshake, code_in = received codeword
//   out_valid/out_ready     output handshake
//   data_out                corrected (or, on double error, raw) data
//   err_single/err_double   corrected single error / uncorrectable error
//   err_pos                 corrected position, 0 when not a single error
//   cnt_clr, cnt_single,    error counters, present only when the macro
//   cnt_double              HAM_ERR_CNT_EN is defined
module hamming_secded_decoder
    import ham_pkg::*;
#(
    parameter int  DATA_W = 11,
    parameter int  CNT_W  = 16,
    localparam int R      = calc_r(DATA_W),
    localparam int CODE_W = calc_code_w(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              parity_type,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] code_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic              err_single,
    output logic              err_double,
    output logic [R:0]        err_pos
`ifdef HAM_ERR_CNT_EN
    ,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_single,
    output logic [CNT_W-1:0]  cnt_double
`endif
);

    logic s1_ready, s2_ready;
    logic [R-1:0] syn;
    logic chk;

    logic              s1_valid_q, s1_valid_d;
    logic [CODE_W-1:0] s1_code_q, s1_code_d;
    logic [R-1:0]      s1_syn_q, s1_syn_d;
    logic              s1_chk_q, s1_chk_d;

    logic              s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_single_q, err_single_d;
    logic              err_double_q, err_double_d;
    logic [R:0]        err_pos_q, err_pos_d;

    err_class_t        cls;
    logic [R:0]        syn_ext;
    logic [CODE_W-1:0] flip_mask;
    logic [CODE_W-1:0] fixed_code;
    logic [DATA_W-1:0] data_fix;
    logic              unused_sink;

    ham_syndrome #(
        .CODE_W (CODE_W),
        .R      (R)
    ) u_syndrome (
        .code        (code_in),
        .parity_type (parity_type),
        .syn         (syn),
        .chk         (chk)
    );

    // A stage may load when it is empty or its content leaves this cycle.
    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_syn_d   = s1_syn_q;
        s1_chk_d   = s1_chk_q;
        if (s1_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_code_d = code_in;
                s1_syn_d  = syn;
                s1_chk_d  = chk;
            end
        end
    end

    // Odd overall parity with a syndrome beyond the codeword cannot be a
    // single flip, so it is reported as uncorrectable and left untouched.
    always_comb begin
        syn_ext = {1'b0, s1_syn_q};
        if (!s1_chk_q) begin
            cls = (s1_syn_q == '0) ? CLEAN : DOUBLE;
        end else if (syn_ext < (R+1)'(CODE_W)) begin
            cls = SINGLE;
        end else begin
            cls = DOUBLE;
        end
        flip_mask  = CODE_W'(cls == SINGLE) << s1_syn_q;
        fixed_code = s1_code_q ^ flip_mask;
    end

    genvar gi;
    generate
        for (gi = 1; gi < CODE_W; gi++) begin : g_data
            if (!is_pow2(gi)) begin : g_map
                assign data_fix[data_index(gi)] = fixed_code[gi];
            end
        end
    endgenerate

    // Parity positions of the corrected word are intentionally dropped.
    assign unused_sink = (^fixed_code) ^ (CNT_W > 0);

    always_comb begin
        s2_valid_d   = s2_valid_q;
        data_d       = data_q;
        err_single_d = err_single_q;
        err_double_d = err_double_q;
        err_pos_d    = err_pos_q;
        if (s2_ready) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                data_d       = data_fix;
                err_single_d = (cls == SINGLE);
                err_double_d = (cls == DOUBLE);
                err_pos_d    = (cls == SINGLE) ? syn_ext : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            s1_code_q    <= '0;
            s1_syn_q     <= '0;
            s1_chk_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            data_q       <= '0;
            err_single_q <= 1'b0;
            err_double_q <= 1'b0;
            err_pos_q    <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_code_q    <= s1_code_d;
            s1_syn_q     <= s1_syn_d;
            s1_chk_q     <= s1_chk_d;
            s2_valid_q   <= s2_valid_d;
            data_q       <= data_d;
            err_single_q <= err_single_d;
            err_double_q <= err_double_d;
            err_pos_q    <= err_pos_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign data_out   = data_q;
    assign err_single = err_single_q;
    assign err_double = err_double_q;
    assign err_pos    = err_pos_q;

`ifdef HAM_ERR_CNT_EN
    logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
    logic [CNT_W-1:0] cnt_double_q, cnt_double_d;
    logic             out_fire;

    assign out_fire = s2_valid_q && out_ready;

    // Clear wins over increment; counters stick at all-ones.
    always_comb begin
        cnt_single_d = cnt_single_q;
        cnt_double_d = cnt_double_q;
        if (cnt_clr) begin
            cnt_single_d = '0;
            cnt_double_d = '0;
        end else begin
            if (out_fire && err_single_q && (cnt_single_q != '1)) begin
                cnt_single_d = cnt_single_q + 1'b1;
            end
            if (out_fire && err_double_q && (cnt_double_q != '1)) begin
                cnt_double_d = cnt_double_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_single_q <= '0;
            cnt_double_q <= '0;
        end else begin
            cnt_single_q <= cnt_single_d;
            cnt_double_q <= cnt_double_d;
        end
    end

    assign cnt_single = cnt_single_q;
    assign cnt_double = cnt_double_q;
`endif

endmodule
